dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory target answering the core's dmem load/store requests. Word-addressed 1RW array
//  behind a valid/ready request + valid/ready response handshake. One outstanding request;
//  response LATENCY cycles after accept. Flags misaligned and out-of-range accesses with resp_err.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words; power of 2, >= 4
//  LATENCY      1             cycles from request accept to resp_valid; 1..15
//  TOHOST_ADDR  32'h0000_1000 byte address of the tohost register (used only with DMEM_TOHOST_EN)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept a request
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data
//  req_be       in   4   store byte enables; bit i covers wdata[8i+7:8i]; ignored on loads
//  resp_valid   out  1   response present
//  resp_ready   in   1   consumer takes the response
//  resp_rdata   out  32  load data; 0 for stores and errors
//  resp_err     out  1   access was misaligned or out of range
//  tohost       out  32  last value written to TOHOST_ADDR (0 without DMEM_TOHOST_EN)
//  tohost_vld   out  1   1-cycle pulse on each tohost write (0 without DMEM_TOHOST_EN)
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, tohost=0,
//    tohost_vld=0, counter=0. Array contents not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. Accept = req_valid & req_ready; req_ready=1 only in IDLE.
//  - Accept in IDLE: transaction is resolved at this clock edge: err computed; a store without
//    err commits the enabled bytes to the array; a load without err latches array[word] into the
//    read register. Next state: RESP if LATENCY==1, else WAIT with counter=LATENCY-1.
//  - WAIT: counter decrements each cycle; at counter==1, next state is RESP. WAIT lasts LATENCY-1 cycles.
//  - RESP: resp_valid=1 with rdata/err held stable until resp_ready; RESP & resp_ready -> IDLE.
//    A new request is not accepted in the same cycle as the response handshake; minimum spacing
//    between accepts is LATENCY+1 cycles.
//  - Word index = req_addr[$clog2(DEPTH_WORDS)+1:2]. err = (req_addr[1:0]!=0) |
//    (req_addr >= 4*DEPTH_WORDS). On err, no array write; resp_rdata=0.
//  - Store with req_be==0: legal no-op write; response has err=0.
//  - Load data is the full word; sub-word extraction and sign extension belong to the core.
//  - Load after store to the same word returns the new data; there is no bypass hazard
//    because only one request is outstanding.
//  - rst mid-transaction: outstanding response is dropped, and a store committed at accept remains.
//  - req_* inputs are sampled only at accept; changes while req_ready=0 are ignored.
// CONFIGURATION
//  DMEM_TOHOST_EN defined: an aligned store to TOHOST_ADDR writes enabled bytes into tohost,
//    does not touch the array, and pulses tohost_vld in the cycle after accept. Its response has
//    err=0 even when TOHOST_ADDR is beyond the array. Loads from TOHOST_ADDR return tohost.
//  DMEM_TOHOST_EN undefined: tohost/tohost_vld tied 0; TOHOST_ADDR decodes as a normal address.
// STRUCTURE
//  dmem_pkg: state enum typedef (IDLE/WAIT/RESP), DMEM_WORD_W=32, DMEM_BE_W=4, and an
//    err-check function (addr, depth) -> bit.
//  Sub-module dmem_sram_1rw: 1RW array, write with per-byte enable, registered read port.
//    This module holds the FSM, the counter, decode, the response registers and tohost.
// TESTING
//  1. Store 0xDEADBEEF @0x10 be=F, then load @0x10 -> resp_rdata=0xDEADBEEF, err=0,
//     resp_valid exactly LATENCY cycles after each accept.
//  2. Store 0x11223344 @0x20 be=F, then store 0xAABBCCDD be=4'b0101, load -> 0x11BB33DD.
//  3. Load @0x13 (misaligned) and load @4*DEPTH_WORDS -> err=1, rdata=0, array unchanged.
//  4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0 until the
//     handshake completes.
//  5. Assert rst during WAIT (LATENCY=4) -> next cycle req_ready=1, resp_valid=0, and no response
//     is produced later.
//  6. DMEM_TOHOST_EN: store 0x1 @TOHOST_ADDR -> tohost=1, a single tohost_vld pulse, and a load
//     @TOHOST_ADDR returns 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, widths and the address legality check for the dmem responder.
// The tohost register is enabled by defining DMEM_TOHOST_EN.
package dmem_pkg;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // An access is illegal when it is not word aligned or falls past the end of the array.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_sram_1rw.sv
// Single-port word array with per-byte write enables and a registered read port.
// The read register only changes on an enabled read, so it holds steady until the next load.
module dmem_sram_1rw
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    input  logic [DMEM_BE_W-1:0]   be,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];
    logic [DMEM_WORD_W-1:0] rdata_q;

    // NOTE: storage arrays get no reset; clearing them would force a flop-per-bit array instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DMEM_BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one outstanding load/store, response LATENCY cycles after accept.
// Define DMEM_TOHOST_EN to map a tohost register at TOHOST_ADDR.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] tohost,
    output logic        tohost_vld
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

`ifdef DMEM_TOHOST_EN
    localparam bit TOHOST_EN = 1'b1;
`else
    localparam bit TOHOST_EN = 1'b0;
`endif

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        err_q, err_d;
    logic        rd_sel_q, rd_sel_d;
    logic        th_rd_q, th_rd_d;
    logic [31:0] tohost_q, tohost_d;
    logic        tohost_vld_q, tohost_vld_d;

    logic        accept;
    logic        hit_tohost;
    logic        addr_err;
    logic        sram_en;
    logic [31:0] sram_rdata;

    assign accept     = req_valid & req_ready_q;
    assign hit_tohost = TOHOST_EN && (TOHOST_ADDR[1:0] == 2'b00) && (req_addr == TOHOST_ADDR);
    assign addr_err   = dmem_addr_err(req_addr, $unsigned(DEPTH_WORDS));

    // NOTE: every signal gets its default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        err_d        = err_q;
        rd_sel_d     = rd_sel_q;
        th_rd_d      = th_rd_q;
        tohost_d     = tohost_q;
        tohost_vld_d = 1'b0;
        sram_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // The whole transaction resolves here; later states only pace the response.
                    err_d       = hit_tohost ? 1'b0 : addr_err;
                    rd_sel_d    = !req_we && !hit_tohost && !addr_err;
                    th_rd_d     = !req_we && hit_tohost;
                    sram_en     = !hit_tohost && !addr_err && !rst;
                    req_ready_d = 1'b0;
                    if (hit_tohost && req_we) begin
                        for (int i = 0; i < DMEM_BE_W; i++) begin
                            if (req_be[i]) begin
                                tohost_d[8*i +: 8] = req_wdata[8*i +: 8];
                            end
                        end
                        tohost_vld_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    cnt_d        = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    err_d        = 1'b0;
                    rd_sel_d     = 1'b0;
                    th_rd_d      = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_sel_q     <= 1'b0;
            th_rd_q      <= 1'b0;
            tohost_q     <= 32'd0;
            tohost_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rd_sel_q     <= rd_sel_d;
            th_rd_q      <= th_rd_d;
            tohost_q     <= tohost_d;
            tohost_vld_q <= tohost_vld_d;
        end
    end

    dmem_sram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (req_we),
        .addr  (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (sram_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rd_sel_q ? sram_rdata : (th_rd_q ? tohost_q : 32'd0);
    assign tohost     = TOHOST_EN ? tohost_q : 32'd0;
    assign tohost_vld = TOHOST_EN ? tohost_vld_q : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=4).
// Define DMEM_TOHOST_EN for both RTL and bench to exercise the tohost register.
module tb_dmem_responder;

    localparam int          DEPTH  = 1024;
    localparam int          LAT    = 4;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] tohost;
    logic        tohost_vld;

    int vectors       = 0;
    int miscompares   = 0;
    int tohost_pulses = 0;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .TOHOST_ADDR (TOHOST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .tohost     (tohost),
        .tohost_vld (tohost_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tohost_vld === 1'b1) tohost_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request from a post-edge point; returns once resp_valid is seen, and
    // completes the handshake too when resp_ready is high. lat counts cycles after accept.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic [31:0] rdata,
                          output logic err);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        req_be    = 4'hF;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (resp_ready === 1'b1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        logic [31:0] rd;
        logic        er;
        do_req(we, addr, wdata, be, lat, rd, er);
        check({tag, ".lat"}, 32'(lat), LAT);
        check({tag, ".rdata"}, rd, exp_rdata);
        check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic        stable;
        logic        seen;
        int          pulses_before;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("rst.req_ready",  {31'd0, req_ready},  32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata,          32'd0);
        check("rst.resp_err",   {31'd0, resp_err},   32'd0);
        check("rst.tohost",     tohost,              32'd0);
        check("rst.tohost_vld", {31'd0, tohost_vld}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word store then load back.
        txn("t1.st", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
        txn("t1.ld", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        check("t1.idle_ready", {31'd0, req_ready}, 32'd1);

        // Byte-enable merge, then a be=0 store that must change nothing.
        txn("t2.st0", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
        txn("t2.st1", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
        txn("t2.ld",  1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);
        txn("t2.be0", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
        txn("t2.ld2", 1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);

        // Error cases: misaligned and out of range, with aliasing words left unchanged.
        txn("t3.st_w1",  1'b1, 32'h4,   32'h0000_4444, 4'hF, 32'd0, 1'b0);
        txn("t3.st_w0",  1'b1, 32'h0,   32'h0000_0055, 4'hF, 32'd0, 1'b0);
        txn("t3.ld_mis", 1'b0, 32'h13,  32'd0, 4'h0, 32'd0, 1'b1);
        txn("t3.st_mis", 1'b1, 32'h12,  32'h1234_5678, 4'hF, 32'd0, 1'b1);
        txn("t3.ld_oor", 1'b0, 32'h1000 + 32'h4, 32'd0, 4'h0, 32'd0, 1'b1);
        txn("t3.st_oor", 1'b1, 32'h1004, 32'h9999_9999, 4'hF, 32'd0, 1'b1);
        txn("t3.ld_hi",  1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'd0, 1'b1);
        txn("t3.chk_w4", 1'b0, 32'h10,  32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        txn("t3.chk_w1", 1'b0, 32'h4,   32'd0, 4'h0, 32'h0000_4444, 1'b0);
        txn("t3.st_top", 1'b1, 32'hFFC, 32'h7777_0001, 4'hF, 32'd0, 1'b0);
        txn("t3.ld_top", 1'b0, 32'hFFC, 32'd0, 4'h0, 32'h7777_0001, 1'b0);

        // Back-pressure: response must hold while a competing request is ignored.
        resp_ready = 1'b0;
        do_req(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
        check("t4.lat",   32'(lat), LAT);
        check("t4.rdata", rd, 32'hDEAD_BEEF);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'd0;
        req_be    = 4'hF;
        stable    = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF ||
                resp_err !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
        end
        check("t4.stable", {31'd0, stable}, 32'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("t4.post_valid", {31'd0, resp_valid}, 32'd0);
        check("t4.post_ready", {31'd0, req_ready},  32'd1);
        txn("t4.ld_again", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT drops the response but keeps the committed store.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t5.in_wait", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5.rst_ready", {31'd0, req_ready},  32'd1);
        check("t5.rst_valid", {31'd0, resp_valid}, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        check("t5.no_resp", {31'd0, seen}, 32'd0);
        txn("t5.ld", 1'b0, 32'h30, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // tohost register access.
        pulses_before = tohost_pulses;
`ifdef DMEM_TOHOST_EN
        txn("t6.st", 1'b1, TOHOST, 32'h0000_0001, 4'hF, 32'd0, 1'b0);
        check("t6.tohost", tohost, 32'h0000_0001);
        check("t6.pulses", 32'(tohost_pulses - pulses_before), 32'd1);
        txn("t6.ld", 1'b0, TOHOST, 32'd0, 4'h0, 32'h0000_0001, 1'b0);
        txn("t6.st_be", 1'b1, TOHOST, 32'h0000_AB00, 4'b0010, 32'd0, 1'b0);
        check("t6.tohost_be", tohost, 32'h0000_AB01);
        check("t6.pulses2", 32'(tohost_pulses - pulses_before), 32'd2);
`else
        txn("t6.st", 1'b1, TOHOST, 32'h0000_0001, 4'hF, 32'd0, 1'b1);
        check("t6.tohost", tohost, 32'd0);
        check("t6.pulses", 32'(tohost_pulses - pulses_before), 32'd0);
        txn("t6.ld", 1'b0, TOHOST, 32'd0, 4'h0, 32'd0, 1'b1);
`endif
        txn("t6.w0_intact", 1'b0, 32'h0, 32'd0, 4'h0, 32'h0000_0055, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
